// File: rtl/exc_pkg.sv
// Shared constants for the exception writeback controller: exception codes,
// status-register index and FSM state encoding.
package exc_pkg;

    localparam logic [31:0] EXC_NONE = 32'd0;
    localparam logic [31:0] EXC_ADD  = 32'd1;
    localparam logic [31:0] EXC_ADDI = 32'd2;
    localparam logic [31:0] EXC_SUB  = 32'd3;
    localparam logic [31:0] EXC_MUL  = 32'd4;
    localparam logic [31:0] EXC_DIV  = 32'd5;

    localparam int RSTATUS_ADDR = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2
    } exc_state_e;

endpackage

// File: rtl/exception_wb_ctrl_if.sv
// Exception event inputs, writeback-port arbitration and pipeline control
// outputs of the exception writeback controller.
interface exception_wb_ctrl_if #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              alu_exc_valid;
    logic [CODE_W-1:0] alu_exc_code;
    logic              md_exc_valid;
    logic [CODE_W-1:0] md_exc_code;
    logic              wb_busy;
    logic              exc_we;
    logic [4:0]        exc_waddr;
    logic [CODE_W-1:0] exc_wdata;
    logic              flush;
    logic              stall;
    logic [CW-1:0]     pending;
    logic              ovf_err;

    modport master (
        output alu_exc_valid, alu_exc_code, md_exc_valid, md_exc_code, wb_busy,
        input  exc_we, exc_waddr, exc_wdata, flush, stall, pending, ovf_err
    );

    modport slave (
        input  alu_exc_valid, alu_exc_code, md_exc_valid, md_exc_code, wb_busy,
        output exc_we, exc_waddr, exc_wdata, flush, stall, pending, ovf_err
    );

endinterface

// File: rtl/exc_fifo.sv
// Dual-push, single-pop circular buffer. Port A is written before port B, so
// A holds the older entry when both push in the same cycle.
module exc_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_a,
    input  logic [CODE_W-1:0] data_a,
    input  logic              push_b,
    input  logic [CODE_W-1:0] data_b,
    input  logic              pop,
    output logic [CODE_W-1:0] head,
    output logic [CW-1:0]     count
);
    logic [DEPTH-1:0][CODE_W-1:0] mem_q, mem_d;
    logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d, wr_b;
    logic [CW-1:0]                count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        wr_b  = wr_q + AW'(push_a);
        if (push_a) mem_d[wr_q] = data_a;
        if (push_b) mem_d[wr_b] = data_b;
        wr_d    = wr_q + AW'(push_a) + AW'(push_b);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/exception_wb_ctrl.sv
// Queues ALU and mult/div exceptions and writes their codes into the status
// register through writeback-port slots left free by the normal path.
module exception_wb_ctrl
    import exc_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CODE_W       = 32,
    parameter int RSTATUS_ADDR = exc_pkg::RSTATUS_ADDR,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input logic                 clock,
    input logic                 reset_n,
    exception_wb_ctrl_if.slave  bus
);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    exc_state_e        state_q, state_d;
    logic              exc_we_q, exc_we_d;
    logic [CODE_W-1:0] exc_wdata_q, exc_wdata_d;
    logic              flush_q, flush_d;
    logic              ovf_err_q, ovf_err_d;

    logic              md_ev, alu_ev, push_md, push_alu, pop, dropped;
    logic [CW:0]       free;
    logic [CW-1:0]     count, count_after;
    logic [CODE_W-1:0] head;

    assign md_ev  = bus.md_exc_valid  && (bus.md_exc_code  != CODE_W'(EXC_NONE));
    assign alu_ev = bus.alu_exc_valid && (bus.alu_exc_code != CODE_W'(EXC_NONE));

    always_comb begin
        pop = (state_q != IDLE) && !bus.wb_busy && (count != '0);
        // Free slots include the one released by a same-cycle pop; md is older
        // and claims a slot before alu.
        free        = DEPTH_W - {1'b0, count} + (CW+1)'(pop);
        push_md     = md_ev && (free != '0);
        push_alu    = alu_ev && (free > (CW+1)'(push_md));
        dropped     = (md_ev && !push_md) || (alu_ev && !push_alu);
        ovf_err_d   = ovf_err_q | dropped;
        flush_d     = push_md | push_alu;
        count_after = count + CW'(push_md) + CW'(push_alu) - CW'(pop);

        state_d     = state_q;
        exc_we_d    = 1'b0;
        exc_wdata_d = exc_wdata_q;
        case (state_q)
            IDLE: if (push_md || push_alu) state_d = ARB;
            ARB, WRITE: begin
                if (pop) begin
                    exc_we_d    = 1'b1;
                    exc_wdata_d = head;
                    state_d     = WRITE;
                end else begin
                    state_d = (count_after != '0) ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            exc_we_q    <= 1'b0;
            exc_wdata_q <= '0;
            flush_q     <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exc_we_q    <= exc_we_d;
            exc_wdata_q <= exc_wdata_d;
            flush_q     <= flush_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    exc_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_a  (push_md),
        .data_a  (bus.md_exc_code),
        .push_b  (push_alu),
        .data_b  (bus.alu_exc_code),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    assign bus.exc_we    = exc_we_q;
    assign bus.exc_waddr = 5'(RSTATUS_ADDR);
    assign bus.exc_wdata = exc_wdata_q;
    assign bus.flush     = flush_q;
    assign bus.stall     = (count >= CW'(DEPTH - 1));
    assign bus.pending   = count;
    assign bus.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_exception_wb_ctrl.sv
// Directed and randomized bench for exception_wb_ctrl against a queue-based
// model of the exception queue and writeback-slot usage.
module tb_exception_wb_ctrl;
    import exc_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CODE_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    exception_wb_ctrl_if #(.DEPTH(DEPTH), .CODE_W(CODE_W)) bus ();

    exception_wb_ctrl #(.DEPTH(DEPTH), .CODE_W(CODE_W), .RSTATUS_ADDR(30)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Reference model: a queue of codes; a write slot is taken whenever the
    // queue was non-empty at the start of a cycle and the port is free.
    logic [CODE_W-1:0] q[$];
    bit                m_we, m_flush, m_ovf;
    logic [CODE_W-1:0] m_wdata;
    int                checks = 0;
    int                passed = 0;

    task automatic model_reset();
        q.delete();
        m_we = 0; m_flush = 0; m_ovf = 0; m_wdata = '0;
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic step(input bit mv, input logic [CODE_W-1:0] mc,
                        input bit av, input logic [CODE_W-1:0] ac, input bit busy);
        int sz, free;
        bit pop, acc;
        logic [CODE_W-1:0] front;
        bus.md_exc_valid = mv; bus.md_exc_code = mc;
        bus.alu_exc_valid = av; bus.alu_exc_code = ac;
        bus.wb_busy = busy;
        @(posedge clock);
        sz    = q.size();
        pop   = (sz > 0) && !busy;
        front = pop ? q[0] : '0;
        free  = DEPTH - sz + int'(pop);
        acc   = 0;
        if (pop) void'(q.pop_front());
        if (mv && mc != 0) begin
            if (free > 0) begin q.push_back(mc); free--; acc = 1; end
            else m_ovf = 1;
        end
        if (av && ac != 0) begin
            if (free > 0) begin q.push_back(ac); free--; acc = 1; end
            else m_ovf = 1;
        end
        m_we = pop;
        if (pop) m_wdata = front;
        m_flush = acc;
        #1;
    endtask

    task automatic idle(input bit busy);
        step(0, '0, 0, '0, busy);
    endtask

    task automatic test_reset();
        bus.md_exc_valid = 0; bus.md_exc_code = '0;
        bus.alu_exc_valid = 0; bus.alu_exc_code = '0;
        bus.wb_busy = 0;
        model_reset();
        #3;
        checks++; if (bus.exc_we !== 1'b0) $display("FAIL reset_we got %b want 0", bus.exc_we); else passed++;
        checks++; if (bus.exc_wdata !== '0) $display("FAIL reset_wdata got %0h want 0", bus.exc_wdata); else passed++;
        checks++; if (bus.flush !== 1'b0) $display("FAIL reset_flush got %b want 0", bus.flush); else passed++;
        checks++; if (bus.pending !== '0) $display("FAIL reset_pending got %0d want 0", bus.pending); else passed++;
        checks++; if (bus.ovf_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf_err); else passed++;
        checks++; if (bus.exc_waddr !== 5'd30) $display("FAIL reset_waddr got %0d want 30", bus.exc_waddr); else passed++;
        @(negedge clock);
        reset_n = 1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        step(0, '0, 1, EXC_SUB, 0);
        checks++; if (bus.flush !== 1'b1) $display("FAIL single_flush got %b want 1", bus.flush); else passed++;
        checks++; if (bus.exc_we !== 1'b0) $display("FAIL single_we_early got %b want 0", bus.exc_we); else passed++;
        checks++; if (bus.pending !== CW'(1)) $display("FAIL single_pending got %0d want 1", bus.pending); else passed++;
        idle(0);
        checks++; if (bus.exc_we !== 1'b1) $display("FAIL single_we got %b want 1", bus.exc_we); else passed++;
        checks++; if (bus.exc_wdata !== EXC_SUB) $display("FAIL single_wdata got %0d want 3", bus.exc_wdata); else passed++;
        checks++; if (bus.exc_waddr !== 5'd30) $display("FAIL single_waddr got %0d want 30", bus.exc_waddr); else passed++;
        checks++; if (bus.flush !== 1'b0) $display("FAIL single_flush_pulse got %b want 0", bus.flush); else passed++;
        checks++; if (bus.pending !== '0) $display("FAIL single_pending_end got %0d want 0", bus.pending); else passed++;
        idle(0);
        checks++; if (bus.exc_we !== 1'b0) $display("FAIL single_we_once got %b want 0", bus.exc_we); else passed++;
    endtask

    task automatic test_back_to_back();
        step(1, EXC_DIV, 1, EXC_ADD, 0);
        checks++; if (bus.flush !== 1'b1) $display("FAIL dual_flush got %b want 1", bus.flush); else passed++;
        checks++; if (bus.pending !== CW'(2)) $display("FAIL dual_pending got %0d want 2", bus.pending); else passed++;
        idle(0);
        checks++; if (bus.flush !== 1'b0) $display("FAIL dual_flush_single got %b want 0", bus.flush); else passed++;
        checks++; if (bus.exc_we !== 1'b1 || bus.exc_wdata !== EXC_DIV)
            $display("FAIL dual_first got we=%b data=%0d want we=1 data=5", bus.exc_we, bus.exc_wdata); else passed++;
        idle(0);
        checks++; if (bus.exc_we !== 1'b1 || bus.exc_wdata !== EXC_ADD)
            $display("FAIL dual_second got we=%b data=%0d want we=1 data=1", bus.exc_we, bus.exc_wdata); else passed++;
        idle(0);
        checks++; if (bus.exc_we !== 1'b0 || bus.pending !== '0)
            $display("FAIL dual_done got we=%b pending=%0d want 0/0", bus.exc_we, bus.pending); else passed++;
    endtask

    task automatic test_contention();
        step(0, '0, 1, EXC_ADDI, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            checks++; if (bus.exc_we !== 1'b0) $display("FAIL busy_hold%0d got we=%b want 0", i, bus.exc_we); else passed++;
        end
        idle(0);
        checks++; if (bus.exc_we !== 1'b1 || bus.exc_wdata !== EXC_ADDI)
            $display("FAIL busy_release got we=%b data=%0d want we=1 data=2", bus.exc_we, bus.exc_wdata); else passed++;
        idle(0);
    endtask

    task automatic test_full();
        logic [CODE_W-1:0] seen[$];
        logic [CODE_W-1:0] want[$];
        step(0, '0, 1, EXC_ADD, 1);
        step(0, '0, 1, EXC_ADDI, 1);
        checks++; if (bus.stall !== 1'b0) $display("FAIL full_stall2 got %b want 0", bus.stall); else passed++;
        step(1, EXC_MUL, 0, '0, 1);
        checks++; if (bus.stall !== 1'b1) $display("FAIL full_stall3 got %b want 1", bus.stall); else passed++;
        checks++; if (bus.ovf_err !== 1'b0) $display("FAIL full_ovf_early got %b want 0", bus.ovf_err); else passed++;
        step(1, EXC_DIV, 1, EXC_SUB, 1);
        checks++; if (bus.pending !== CW'(4)) $display("FAIL full_pending got %0d want 4", bus.pending); else passed++;
        checks++; if (bus.ovf_err !== 1'b1) $display("FAIL full_ovf got %b want 1", bus.ovf_err); else passed++;
        checks++; if (bus.flush !== 1'b1) $display("FAIL full_flush got %b want 1", bus.flush); else passed++;
        want = '{EXC_ADD, EXC_ADDI, EXC_MUL, EXC_DIV};
        for (int i = 0; i < 8; i++) begin
            idle(0);
            if (bus.exc_we === 1'b1) seen.push_back(bus.exc_wdata);
        end
        checks++; if (seen.size() != 4) $display("FAIL full_write_count got %0d want 4", seen.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= seen.size() || seen[i] !== want[i])
                $display("FAIL full_order%0d got %0d want %0d", i, (i < seen.size()) ? seen[i] : '1, want[i]);
            else passed++;
        end
        checks++; if (bus.ovf_err !== 1'b1) $display("FAIL full_ovf_sticky got %b want 1", bus.ovf_err); else passed++;
    endtask

    task automatic test_ignore_reset();
        step(1, EXC_NONE, 1, EXC_NONE, 0);
        checks++; if (bus.flush !== 1'b0) $display("FAIL ignore_flush got %b want 0", bus.flush); else passed++;
        checks++; if (bus.pending !== '0) $display("FAIL ignore_pending got %0d want 0", bus.pending); else passed++;
        step(1, EXC_MUL, 1, EXC_ADDI, 0);
        idle(0);
        checks++; if (bus.exc_we !== 1'b1) $display("FAIL rst_write_active got %b want 1", bus.exc_we); else passed++;
        #2;
        reset_n = 0;
        model_reset();
        #1;
        checks++; if (bus.exc_we !== 1'b0) $display("FAIL rst_we_async got %b want 0", bus.exc_we); else passed++;
        checks++; if (bus.pending !== '0) $display("FAIL rst_pending got %0d want 0", bus.pending); else passed++;
        checks++; if (bus.ovf_err !== 1'b0) $display("FAIL rst_ovf got %b want 0", bus.ovf_err); else passed++;
        @(negedge clock);
        reset_n = 1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            idle(0);
            checks++; if (bus.exc_we !== 1'b0) $display("FAIL rst_no_write%0d got %b want 0", i, bus.exc_we); else passed++;
        end
    endtask

    task automatic test_random();
        bit mv, av, busy;
        logic [CODE_W-1:0] mc, ac;
        for (int i = 0; i < 400; i++) begin
            mv   = ($urandom_range(0, 2) == 0);
            av   = ($urandom_range(0, 2) == 0);
            mc   = (($urandom_range(0, 3) == 0) ? EXC_NONE : CODE_W'($urandom_range(4, 5)));
            ac   = CODE_W'($urandom_range(0, 3));
            busy = ($urandom_range(0, 1) == 1);
            step(mv, mc, av, ac, busy);
            checks++; if (bus.exc_we !== m_we) $display("FAIL rnd_we c%0d got %b want %b", i, bus.exc_we, m_we); else passed++;
            checks++; if (bus.exc_wdata !== m_wdata) $display("FAIL rnd_wdata c%0d got %0d want %0d", i, bus.exc_wdata, m_wdata); else passed++;
            checks++; if (bus.flush !== m_flush) $display("FAIL rnd_flush c%0d got %b want %b", i, bus.flush, m_flush); else passed++;
            checks++; if (bus.pending !== CW'(q.size())) $display("FAIL rnd_pending c%0d got %0d want %0d", i, bus.pending, q.size()); else passed++;
            checks++; if (bus.stall !== (q.size() >= DEPTH - 1)) $display("FAIL rnd_stall c%0d got %b want %b", i, bus.stall, q.size() >= DEPTH - 1); else passed++;
            checks++; if (bus.ovf_err !== m_ovf) $display("FAIL rnd_ovf c%0d got %b want %b", i, bus.ovf_err, m_ovf); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_full();
        test_ignore_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/exception_wb_ctrl.md
Name: exception_wb_ctrl

Overview:
- Collects exception events from the execute-stage exception decode (ALU add/addi/sub overflow) and from the multiply/divide unit.
- Queues the events in a small in-order FIFO.
- Writes each exception code into the status register (r30) through the shared register-file writeback port, using only the cycles the normal writeback path leaves free.
- Emits a one-cycle flush to the pipeline for every accepted exception, and a stall when the queue cannot guarantee space.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CODE_W, 32, width of an exception code and of the write data.
- RSTATUS_ADDR, 30, register-file index of the status register.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- alu_exc_valid  in  1  ALU-stage exception this cycle.
- alu_exc_code  in  CODE_W  code: 1=add, 2=addi, 3=sub.
- md_exc_valid  in  1  mult/div completion exception this cycle.
- md_exc_code  in  CODE_W  code: 4=mul, 5=div.
- wb_busy  in  1  normal writeback owns the register-file port this cycle.
- exc_we  out  1  exception write enable to the register-file port.
- exc_waddr  out  5  write address; always RSTATUS_ADDR.
- exc_wdata  out  CODE_W  exception code being written.
- flush  out  1  one-cycle squash of younger instructions.
- stall  out  1  upstream must hold; queue nearly full.
- pending  out  $clog2(DEPTH)+1  number of queued entries.
- ovf_err  out  1  sticky; set when an event was dropped.

Behaviour:
- Reset: while reset_n is low, asynchronously clear FIFO pointers, pending, exc_we, exc_wdata, flush and ovf_err to 0. exc_waddr is constant RSTATUS_ADDR.
- Event qualification:
  - An event counts only when valid=1 and code!=0.
  - A valid event with code 0 is ignored: no enqueue, no flush.
- Enqueue order: when both events arrive in the same cycle, enqueue the md event first because it is the older instruction, then the alu event. Up to two pushes per cycle.
- Overflow:
  - Each push needs a free slot, counted after any same-cycle pop.
  - A push without a free slot is dropped and sets ovf_err.
  - ovf_err clears only on reset.
- stall: combinational; stall = (pending >= DEPTH-1). With stall honoured upstream, a two-event cycle always fits.
- flush: registered. It is 1 in cycle N+1 if at least one event was accepted at edge N; otherwise 0. It is a single pulse even when two events were accepted.
- FSM (tracks the head entry):
  - IDLE: FIFO empty; exc_we=0. A push moves to ARB.
  - ARB: head valid.
    - If wb_busy=0: at the edge, register exc_we=1 and exc_wdata=head, pop, and go to WRITE.
    - If wb_busy=1: hold; exc_we=0.
  - WRITE: exc_we is high for exactly this one cycle.
    - Next state is ARB if the FIFO is still non-empty, else IDLE.
    - In WRITE, a new pop may be scheduled for the next cycle if wb_busy=0, so back-to-back writes are allowed.
- Latency: an event accepted at edge N produces exc_we at the earliest in cycle N+2, i.e. N+1 to the ARB decision, then the registered write.
- Pops are strictly in FIFO order, and r30 ends up holding the youngest code.
- Push and pop in the same cycle are allowed; pending adjusts by pushes minus pops.
- wb_busy is sampled only in ARB (and in WRITE for the back-to-back case). exc_we is never asserted in a cycle that was scheduled while wb_busy=1.
- Pointer wrap-around: modulo DEPTH.
- Reset mid-operation: a queued or in-flight write is discarded, and exc_we drops immediately (asynchronous).

Decomposition:
- Shared package, exc_pkg:
  - exception code constants: EXC_NONE=0, EXC_ADD=1, EXC_ADDI=2, EXC_SUB=3, EXC_MUL=4, EXC_DIV=5;
  - RSTATUS_ADDR;
  - FSM state encoding IDLE/ARB/WRITE.
- Sub-module exc_fifo: dual-push, single-pop circular buffer with a count output. The controller FSM and the output registers stay in exception_wb_ctrl.

Test Plan:
- Single event: alu_exc_valid=1, code=3 for one cycle, wb_busy=0 → flush=1 next cycle; exc_we=1 with exc_wdata=3 and exc_waddr=30 two cycles after acceptance; pending returns to 0.
- Dual event: md code=5 and alu code=1 in the same cycle → one flush pulse; pending=2; writes in order 5 then 1 on consecutive cycles.
- Port contention: accept code 2, hold wb_busy=1 for 4 cycles → no exc_we during the hold; write of 2 occurs exactly one cycle after wb_busy falls.
- Full queue: with DEPTH=4 and wb_busy=1, push 3 events → stall=1; push 2 more → one accepted, one dropped; ovf_err=1; after release, 4 writes occur in order.
- Ignore and reset: alu_exc_valid=1 with code=0 → no flush, pending=0. Then queue 2 events and assert reset_n=0 during WRITE → exc_we=0 immediately, pending=0, no further writes after release.
